digit_serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the team's single-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a registered inter-digit carry.
- Valid/ready handshakes on input and output, so it can sit in area-constrained datapaths between producer and consumer stages.
- Reports carry-out and signed overflow.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/digit_add_cell.sv | 29 ++
 rtl/digit_serial_adder.sv | 127 ++++++++++++
 tb/tb_digit_serial_adder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and a
// constant-evaluable ceil(log2) used to size the digit counter.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/digit_add_cell.sv
// Combinational DIGIT-bit ripple adder made of full-adder slices. Also exposes
// the carry entering its top bit so the caller can form signed overflow.
module digit_add_cell #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = carry[DIGIT];
  assign c_msb_o = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB digit first, with a
// registered inter-digit carry. Reports carry-out and signed overflow.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, and a
  // producer/consumer must hold its side steady until that edge.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;

  digit_add_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .c_i    (carry_q),
    .s_o    (dig_sum),
    .c_o    (dig_cout),
    .c_msb_o(dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so B is inverted once here and the
          // "+1" rides in on the initial carry.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: one DIGIT=1 and one DIGIT=4 instance (WIDTH=8)
// sharing operand inputs, compared against an integer-arithmetic reference.
module tb_digit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       in_valid, out_ready;
  logic       sel;  // 0: DIGIT=1 instance, 1: DIGIT=4 instance

  logic       in_valid1, in_valid4, out_ready1, out_ready4;
  logic       in_ready1, in_ready4, out_valid1, out_valid4;
  logic [7:0] sum1, sum4;
  logic       cout1, cout4, ovf1, ovf4;
  logic [1:0] dbg1, dbg4;

  logic       obs_in_ready, obs_out_valid, obs_cout, obs_ovf;
  logic [7:0] obs_sum;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  assign in_valid1  = in_valid && !sel;
  assign in_valid4  = in_valid && sel;
  assign out_ready1 = out_ready && !sel;
  assign out_ready4 = out_ready && sel;

  assign obs_in_ready  = sel ? in_ready4 : in_ready1;
  assign obs_out_valid = sel ? out_valid4 : out_valid1;
  assign obs_sum       = sel ? sum4 : sum1;
  assign obs_cout      = sel ? cout4 : cout1;
  assign obs_ovf       = sel ? ovf4 : ovf1;

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .dbg_state_o(dbg1)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .dbg_state_o(dbg4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic c, input logic s);
    int ux, uy, sx, sy, ures, sres;
    logic [7:0] r_sum;
    logic r_cout, r_ovf;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      ures   = ux - uy;
      sres   = sx - sy;
      r_cout = (ux >= uy);
    end else begin
      ures   = ux + uy + int'(c);
      sres   = sx + sy + int'(c);
      r_cout = (ures > 255);
    end
    r_ovf = (sres > 127) || (sres < -128);
    r_sum = ures[7:0];
    return {r_ovf, r_cout, r_sum};
  endfunction

  // Driver: present one operation to the selected instance, wait for its
  // result. lat is the edge count from accept to out_valid (-1 on timeout).
  task automatic run_op(input logic s, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tcin, input logic tsub, input logic drain,
                        output logic [9:0] got, output int lat);
    sel = s;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tcin; sub = tsub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      if (obs_out_valid) begin
        lat = i - 1;
        break;
      end
      @(posedge clk); #1;
    end
    got = {obs_ovf, obs_cout, obs_sum};
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic check_result(input string name, input logic [9:0] got,
                              input logic [9:0] exp, input int lat, input int exp_lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (got[7:0] !== exp[7:0]) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, got[7:0], exp[7:0]);
    end
    checks++;
    if (got[8] !== exp[8]) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, got[8], exp[8]);
    end
    checks++;
    if (got[9] !== exp[9]) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, got[9], exp[9]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (obs_in_ready !== 1'b1) begin
        errors++; $display("FAIL reset in_ready[%0d]: got %b expected 1", s, obs_in_ready);
      end
      checks++;
      if (obs_out_valid !== 1'b0) begin
        errors++; $display("FAIL reset out_valid[%0d]: got %b expected 0", s, obs_out_valid);
      end
      checks++;
      if ({obs_ovf, obs_cout, obs_sum} !== 10'd0) begin
        errors++; $display("FAIL reset outputs[%0d]: got %h expected 000", s, {obs_ovf, obs_cout, obs_sum});
      end
    end
  endtask

  task automatic test_add_digit1();
    logic [9:0] got; int lat;
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, got, lat);
    check_result("add_d1", got, {1'b1, 1'b0, 8'h96}, lat, 8);
  endtask

  task automatic test_sub_digit1();
    logic [9:0] got; int lat;
    run_op(1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, got, lat);
    check_result("sub_d1", got, {1'b0, 1'b0, 8'hF0}, lat, 8);
  endtask

  task automatic test_add_digit4();
    logic [9:0] got; int lat;
    run_op(1'b1, 8'hAB, 8'hCD, 1'b0, 1'b0, 1'b1, got, lat);
    check_result("add_d4", got, {1'b1, 1'b1, 8'h78}, lat, 2);
  endtask

  task automatic test_backpressure();
    logic [9:0] got; int lat; logic saw_valid;
    run_op(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, got, lat);
    check_result("bp_result", got, {1'b0, 1'b1, 8'h01}, lat, 8);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        a = 8'h33; b = 8'h44; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (obs_out_valid !== 1'b1) begin
        errors++; $display("FAIL bp out_valid cyc%0d: got %b expected 1", k, obs_out_valid);
      end
      checks++;
      if ({obs_ovf, obs_cout, obs_sum} !== {1'b0, 1'b1, 8'h01}) begin
        errors++; $display("FAIL bp hold cyc%0d: got %h expected 101", k, {obs_ovf, obs_cout, obs_sum});
      end
      checks++;
      if (obs_in_ready !== 1'b0) begin
        errors++; $display("FAIL bp in_ready cyc%0d: got %b expected 0", k, obs_in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp release: got in_ready=%b out_valid=%b expected 1/0", obs_in_ready, obs_out_valid);
    end
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (obs_out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL bp ghost result: got out_valid=1 expected none");
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] got; int lat;
    sel = 1'b0;
    @(posedge clk); #1;
    a = 8'hC3; b = 8'h5A; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst out_valid: got %b expected 0", obs_out_valid);
    end
    checks++;
    if (obs_sum !== 8'h00) begin
      errors++; $display("FAIL midrst sum: got %h expected 00", obs_sum);
    end
    checks++;
    if (obs_in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst in_ready: got %b expected 1", obs_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, got, lat);
    check_result("after_rst", got, {1'b0, 1'b0, 8'h02}, lat, 8);
  endtask

  // Scoreboard-driven back-to-back run with in_valid and out_ready held high.
  task automatic test_back_to_back(input logic s, input int ndig);
    logic [9:0] exp, got;
    logic prev_rdy;
    int n_acc, n_res, cyc, last_cyc;
    sel = s;
    exp_q.delete();
    @(posedge clk); #1;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev_rdy = obs_in_ready;
    n_acc = 0; n_res = 0; cyc = 0; last_cyc = -1;
    while (n_res < 16 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_rdy && in_valid) begin
        exp_q.push_back(ref_model(a, b, cin, sub));
        n_acc++;
        if (n_acc == 16) in_valid = 1'b0;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      if (obs_out_valid) begin
        got = {obs_ovf, obs_cout, obs_sum};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b[%0d] unexpected result %h", s, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++; $display("FAIL b2b[%0d] result %0d: got %h expected %h", s, n_res, got, exp);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc !== ndig + 2) begin
            errors++; $display("FAIL b2b[%0d] spacing: got %0d expected %0d", s, cyc - last_cyc, ndig + 2);
          end
        end
        last_cyc = cyc;
        n_res++;
      end
      prev_rdy = obs_in_ready;
    end
    checks++;
    if (n_res !== 16) begin
      errors++; $display("FAIL b2b[%0d] count: got %0d results expected 16", s, n_res);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add_digit1();
    test_sub_digit1();
    test_add_digit4();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back(1'b0, 8);
    test_back_to_back(1'b1, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
